tilelink_ad_master: RTL

TileLink-UL A/D-channel initiator for the formal/simulation harness. It turns a simple single-outstanding command/response interface into TL-UL Get / PutFullData / PutPartialData requests on channel A. It collects the AccessAck / AccessAckData beats from channel D and returns them one response per beat. Its A/D ports attach directly to the A/D ports of the harness's TileLink dummy slave, or to any tile slave port, so DMA-style traffic and bus checks can be driven into a RocketTile.

---
 rtl/tl_ad_pkg.sv | 41 ++++
 rtl/tl_ad_rsp_reg.sv | 70 +++++++
 rtl/tilelink_ad_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ad_pkg.sv
// rtl/tl_ad_pkg.sv - shared TL-UL constants, FSM states and mask helper
//
// Purpose: opcode constants for channels A and D, the initiator FSM state
// enum, and full_mask(), which returns the byte-lane mask that a transfer of
// 2^size bytes covers at a given offset within a beat of bpb bytes.
package tl_ad_pkg;

  localparam logic [2:0] A_PUT_FULL         = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL      = 3'd1;
  localparam logic [2:0] A_GET              = 3'd4;

  localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_A_REQ   = 2'd1,
    ST_D_WAIT  = 2'd2,
    ST_ERR_RSP = 2'd3
  } state_e;

  // Transfers at least one beat wide cover every lane; smaller ones cover
  // 2^size lanes starting at the byte offset.
  function automatic logic [7:0] full_mask(input logic [2:0] offset,
                                           input logic [3:0] size,
                                           input int         bpb);
    logic [7:0] m;
    int         lg;
    int         n;
    m  = '0;
    lg = $clog2(bpb);
    n  = (int'(size) >= lg) ? bpb : (1 << size);
    for (int i = 0; i < 8; i++) begin
      if ((i < bpb) && (i >= int'(offset)) && (i < int'(offset) + n)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/tl_ad_rsp_reg.sv
// rtl/tl_ad_rsp_reg.sv - one-entry response register with valid/ready
//
// Purpose: holds one response (data, last, error). It accepts a new entry in
// the same cycle the current one drains, so a full register still sustains
// one entry per cycle.
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready              load side handshake
//   in_data, in_last, in_error     entry to load
//   out_valid/out_ready            drain side handshake
//   out_data, out_last, out_error  held entry
module tl_ad_rsp_reg
  #(
    parameter int XLEN = 64
  ) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_last,
    input  logic            in_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            out_error
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic            error_q, error_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_error = error_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    error_d = error_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d  = in_data;
        last_d  = in_last;
        error_d = in_error;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

endmodule

// File: rtl/tilelink_ad_master.sv
// rtl/tilelink_ad_master.sv - single-outstanding TL-UL A/D channel initiator
//
// Purpose: turns a cmd_* request into one TL-UL Get/PutFullData/PutPartialData
// on channel A and returns every channel D beat as one rsp_* beat.
// Optional feature macro: TL_MASTER_TIMEOUT_EN (watchdog on A/D stalls).
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   cmd_*                   command in (valid/ready, write, address, size, mask, data)
//   a_*                     TL channel A out
//   d_*                     TL channel D in
//   rsp_*                   response out (valid/ready, data, last, error)
//   proto_err               sticky protocol-violation flag
//   timeout                 sticky watchdog flag (0 without the macro)
module tilelink_ad_master
  import tl_ad_pkg::*;
  #(
    parameter int XLEN           = 64,
    parameter int MAX_LOG2SIZE   = 6,
    parameter int TIMEOUT_CYCLES = 256
  ) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [31:0]         cmd_address,
    input  logic [3:0]          cmd_size,
    input  logic [XLEN/8-1:0]   cmd_mask,
    input  logic [XLEN-1:0]     cmd_data,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_param,
    output logic [3:0]          a_size,
    output logic                a_source,
    output logic [31:0]         a_address,
    output logic [XLEN/8-1:0]   a_mask,
    output logic [XLEN-1:0]     a_data,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [3:0]          d_size,
    input  logic                d_source,
    input  logic                d_sink,
    input  logic [XLEN-1:0]     d_data,
    input  logic                d_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_last,
    output logic                rsp_error,
    output logic                proto_err,
    output logic                timeout
  );

  localparam int         BPB      = XLEN / 8;
  localparam logic [3:0] LG_BPB   = 4'($clog2(BPB));
  localparam logic [3:0] MAX_SIZE = 4'(MAX_LOG2SIZE);

  state_e            state_q, state_d;
  logic              init_q, init_d;
  logic              write_q, write_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [3:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d;
  logic [BPB-1:0]    mask_q, mask_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [2:0]        beat_q, beat_d;
  logic              proto_err_q, proto_err_d;

  logic              rsp_in_valid, rsp_in_ready, rsp_in_last, rsp_in_error;
  logic [XLEN-1:0]   rsp_in_data;

  logic [31:0]       align_mask;
  logic              cmd_illegal;
  logic [7:0]        cmd_full8;
  logic [BPB-1:0]    cmd_full;
  logic [3:0]        beat_shift;
  logic [2:0]        beats_m1;
  logic              d_last, d_check_fail, cmd_fire, a_fire, d_fire;
  logic              unused_ok;

  assign align_mask  = (32'd1 << cmd_size) - 32'd1;
  assign cmd_illegal = (cmd_size > MAX_SIZE) || (cmd_write && (cmd_size > LG_BPB)) ||
                       ((cmd_address & align_mask) != 32'd0);
  assign cmd_full8   = full_mask(cmd_address[2:0] & 3'(BPB - 1), cmd_size, BPB);
  assign cmd_full    = cmd_full8[BPB-1:0];

  // Multi-beat transfers: 2^(size - log2 BPB) beats, counted as beats-1.
  assign beat_shift  = (size_q > LG_BPB) ? (size_q - LG_BPB) : 4'd0;
  assign beats_m1    = 3'((8'd1 << beat_shift) - 8'd1);
  assign d_last      = (beat_q == beats_m1);
  assign d_check_fail = (d_opcode != (write_q ? D_ACCESS_ACK : D_ACCESS_ACK_DATA)) ||
                        (d_source != 1'b0) || (d_size != size_q);

  // init_q keeps the handshakes low until the first edge after reset release.
  assign cmd_ready = (state_q == ST_IDLE) && init_q;
  assign a_valid   = (state_q == ST_A_REQ);
  assign d_ready   = cmd_ready || ((state_q == ST_D_WAIT) && rsp_in_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign a_fire    = a_valid && a_ready;
  assign d_fire    = d_valid && d_ready;

  assign a_opcode  = opcode_q;
  assign a_param   = 3'd0;
  assign a_size    = size_q;
  assign a_source  = 1'b0;
  assign a_address = addr_q;
  assign a_mask    = mask_q;
  assign a_data    = data_q;
  assign proto_err = proto_err_q;
  assign unused_ok = ^{d_param, d_sink, cmd_full8};

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    init_d       = 1'b1;
    write_d      = write_q;
    opcode_d     = opcode_q;
    size_d       = size_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    data_d       = data_q;
    beat_d       = beat_q;
    proto_err_d  = proto_err_q;
    rsp_in_valid = 1'b0;
    rsp_in_data  = '0;
    rsp_in_last  = 1'b0;
    rsp_in_error = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_fire) begin
          proto_err_d = 1'b1;
        end
        if (cmd_fire) begin
          if (cmd_illegal) begin
            state_d = ST_ERR_RSP;
          end else begin
            state_d  = ST_A_REQ;
            write_d  = cmd_write;
            size_d   = cmd_size;
            addr_d   = cmd_address;
            mask_d   = cmd_write ? cmd_mask : cmd_full;
            data_d   = cmd_write ? cmd_data : '0;
            opcode_d = !cmd_write ? A_GET :
                       (cmd_mask == cmd_full) ? A_PUT_FULL : A_PUT_PARTIAL;
          end
        end
      end
      ST_A_REQ: begin
        if (a_fire) begin
          state_d = ST_D_WAIT;
          beat_d  = 3'd0;
        end
      end
      ST_D_WAIT: begin
        if (d_fire) begin
          rsp_in_valid = 1'b1;
          rsp_in_data  = write_q ? '0 : d_data;
          rsp_in_last  = d_last;
          rsp_in_error = d_error || d_check_fail;
          if (d_check_fail) begin
            proto_err_d = 1'b1;
          end
          // Counter stops at beats-1, the last beat leaves the state.
          if (d_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      ST_ERR_RSP: begin
        rsp_in_valid = 1'b1;
        rsp_in_last  = 1'b1;
        rsp_in_error = 1'b1;
        if (rsp_in_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TL_MASTER_TIMEOUT_EN
    tmo_cnt_d = '0;
    timeout_d = timeout_q;
    if (((state_q == ST_A_REQ) && !a_fire) || ((state_q == ST_D_WAIT) && !d_fire)) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_ERR_RSP;
        timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      init_q      <= 1'b0;
      write_q     <= 1'b0;
      opcode_q    <= 3'd0;
      size_q      <= 4'd0;
      addr_q      <= 32'd0;
      mask_q      <= '0;
      data_q      <= '0;
      beat_q      <= 3'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      write_q     <= write_d;
      opcode_q    <= opcode_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef TL_MASTER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  tl_ad_rsp_reg #(.XLEN(XLEN)) u_rsp_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rsp_in_valid),
    .in_ready  (rsp_in_ready),
    .in_data   (rsp_in_data),
    .in_last   (rsp_in_last),
    .in_error  (rsp_in_error),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (rsp_data),
    .out_last  (rsp_last),
    .out_error (rsp_error)
  );

endmodule
